// File: rtl/xc_aessub_seq.sv
// xc_aessub_seq: sequences one shared S-box over four operand bytes for AES SubBytes
module xc_aessub_seq #(
    parameter bit CAPTURE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] flush_data,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic        ready,
    output logic [31:0] result,
    output logic [7:0]  sbox_in,
    output logic        sbox_inv,
    input  logic [7:0]  sbox_out
);
    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3, DONE} state_t;
    state_t      fsm;
    logic [7:0]  b0, b1, b2;
    logic [31:0] cap_rs1, cap_rs2;
    logic        cap_enc, cap_rot;
    logic [31:0] op_rs1, op_rs2;
    logic        op_enc, op_rot, busy;
    // operand source and S-box drive; idle/done present 00 so the S-box stays quiet
    always_comb begin
        op_rs1   = CAPTURE ? cap_rs1 : rs1;
        op_rs2   = CAPTURE ? cap_rs2 : rs2;
        op_enc   = CAPTURE ? cap_enc : enc;
        op_rot   = CAPTURE ? cap_rot : rot;
        busy     = fsm == S0 || fsm == S1 || fsm == S2 || fsm == S3;
        sbox_in  = fsm == S0 ? op_rs1[7:0]   :
                   fsm == S1 ? op_rs2[15:8]  :
                   fsm == S2 ? op_rs1[23:16] :
                   fsm == S3 ? op_rs2[31:24] : 8'h00;
        sbox_inv = busy ? !op_enc : 1'b0;
    end
    // sequencer: flush beats accept and the final result write; dropped valid aborts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm     <= IDLE;
            ready   <= 1'b0;
            result  <= 32'h0;
            b0      <= 8'h0;
            b1      <= 8'h0;
            b2      <= 8'h0;
            cap_rs1 <= 32'h0;
            cap_rs2 <= 32'h0;
            cap_enc <= 1'b0;
            cap_rot <= 1'b0;
        end else if (flush) begin
            fsm    <= IDLE;
            ready  <= 1'b0;
            result <= flush_data;
            b0     <= 8'h0;
            b1     <= 8'h0;
            b2     <= 8'h0;
        end else begin
            ready <= 1'b0;
            case (fsm)
                IDLE: if (valid) begin
                    fsm <= S0;
                    if (CAPTURE) begin
                        cap_rs1 <= rs1;
                        cap_rs2 <= rs2;
                        cap_enc <= enc;
                        cap_rot <= rot;
                    end
                end
                S0: begin
                    fsm <= valid ? S1 : IDLE;
                    if (valid) b0 <= sbox_out;
                end
                S1: begin
                    fsm <= valid ? S2 : IDLE;
                    if (valid) b1 <= sbox_out;
                end
                S2: begin
                    fsm <= valid ? S3 : IDLE;
                    if (valid) b2 <= sbox_out;
                end
                S3: begin
                    fsm <= valid ? DONE : IDLE;
                    if (valid) begin
                        result <= op_rot ? {b2, b1, b0, sbox_out} : {sbox_out, b2, b1, b0};
                        ready  <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xc_aessub_seq.sv
// tb_xc_aessub_seq: directed checks of the SubBytes sequencer with a partial S-box responder
module tb_xc_aessub_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_data = 32'h0;
    logic        valid = 1'b0;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic        enc = 1'b0;
    logic        rot = 1'b0;
    logic        ready;
    logic [31:0] result;
    logic [7:0]  sbox_in;
    logic        sbox_inv;
    logic [7:0]  sbox_out;
    int          n_chk = 0;
    int          n_fail = 0;

    xc_aessub_seq #(.CAPTURE(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush), .flush_data(flush_data),
        .valid(valid), .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
        .ready(ready), .result(result), .sbox_in(sbox_in), .sbox_inv(sbox_inv),
        .sbox_out(sbox_out)
    );

    always #5 clock = ~clock;

    // only the AES S-box entries the vectors touch; anything else maps to ~x
    function automatic logic [7:0] fwd(input logic [7:0] x);
        return x == 8'h00 ? 8'h63 : x == 8'h01 ? 8'h7c : x == 8'h53 ? 8'hed : ~x;
    endfunction
    function automatic logic [7:0] inv(input logic [7:0] x);
        return x == 8'h63 ? 8'h00 : x == 8'h7c ? 8'h01 : x == 8'hed ? 8'h53 : ~x;
    endfunction
    always_comb sbox_out = sbox_inv ? inv(sbox_in) : fwd(sbox_in);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // accept at the current negedge, scramble live operands, walk S0..S3 and DONE
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic e,
                          input logic r, input logic [31:0] exp_res, input logic [31:0] seq);
        rs1 = a; rs2 = b; enc = e; rot = r; valid = 1'b1;
        @(negedge clock);
        rs1 = ~a; rs2 = ~b; enc = ~e; rot = ~r;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clock);
            chk("sbox_in_busy", {24'h0, sbox_in}, {24'h0, seq[31-8*k -: 8]});
            chk("sbox_inv_busy", {31'h0, sbox_inv}, {31'h0, !e});
            chk("ready_busy", {31'h0, ready}, 32'h0);
        end
        @(negedge clock);
        chk("ready_done", {31'h0, ready}, 32'h1);
        chk("result_done", result, exp_res);
        chk("sbox_in_done", {24'h0, sbox_in}, 32'h0);
    endtask

    initial begin
        // reset values
        @(negedge clock);
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_sbox_in", {24'h0, sbox_in}, 32'h0);
        chk("rst_sbox_inv", {31'h0, sbox_inv}, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        // 1: forward, plain packing
        run_op(32'h0053_0000, 32'h0100_0100, 1'b1, 1'b0, 32'h7ced7c63, 32'h00015301);
        valid = 1'b0;
        @(negedge clock);
        chk("t1_idle_ready", {31'h0, ready}, 32'h0);
        chk("t1_hold", result, 32'h7ced7c63);
        chk("t1_idle_sbox", {24'h0, sbox_in}, 32'h0);
        // 2: forward, rotated packing
        run_op(32'h0053_0000, 32'h0100_0100, 1'b1, 1'b1, 32'hed7c637c, 32'h00015301);
        valid = 1'b0;
        @(negedge clock);
        // 3: inverse S-box
        run_op(32'h6363_6363, 32'h6363_6363, 1'b0, 1'b0, 32'h0000_0000, 32'h63636363);
        valid = 1'b0;
        @(negedge clock);
        // 4: back-to-back ops with valid held
        run_op(32'h0053_0000, 32'h0100_0100, 1'b1, 1'b0, 32'h7ced7c63, 32'h00015301);
        @(negedge clock);
        chk("t4_gap_ready", {31'h0, ready}, 32'h0);
        chk("t4_gap_sbox", {24'h0, sbox_in}, 32'h0);
        chk("t4_gap_inv", {31'h0, sbox_inv}, 32'h0);
        run_op(32'h0053_0000, 32'h0100_0100, 1'b1, 1'b1, 32'hed7c637c, 32'h00015301);
        valid = 1'b0;
        @(negedge clock);
        // 5: flush while in S2
        rs1 = 32'h0053_0000; rs2 = 32'h0100_0100; enc = 1'b1; rot = 1'b0; valid = 1'b1;
        repeat (3) @(negedge clock);
        chk("t5_s2_sbox", {24'h0, sbox_in}, 32'h53);
        flush = 1'b1; flush_data = 32'hdead_beef; valid = 1'b0;
        @(negedge clock);
        flush = 1'b0;
        chk("t5_flush_result", result, 32'hdeadbeef);
        chk("t5_flush_idle", {24'h0, sbox_in}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_ready", {31'h0, ready}, 32'h0);
            @(negedge clock);
        end
        chk("t5_hold", result, 32'hdeadbeef);
        // 6a: async reset in S1
        rs1 = 32'h0053_0000; rs2 = 32'h0100_0100; enc = 1'b1; rot = 1'b0; valid = 1'b1;
        repeat (2) @(negedge clock);
        chk("t6_s1_sbox", {24'h0, sbox_in}, 32'h01);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_result", result, 32'h0);
        chk("t6_rst_ready", {31'h0, ready}, 32'h0);
        chk("t6_rst_sbox", {24'h0, sbox_in}, 32'h0);
        @(negedge clock);
        reset = 1'b0; valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("t6_no_ready", {31'h0, ready}, 32'h0);
        end
        // 6b: valid dropped in S3
        rs1 = 32'h0053_0000; rs2 = 32'h0100_0100; enc = 1'b1; rot = 1'b0; valid = 1'b1;
        repeat (4) @(negedge clock);
        chk("t6_s3_sbox", {24'h0, sbox_in}, 32'h01);
        valid = 1'b0;
        @(negedge clock);
        chk("t6_abort_idle", {24'h0, sbox_in}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t6_abort_ready", {31'h0, ready}, 32'h0);
            chk("t6_abort_result", result, 32'h0);
            @(negedge clock);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
